// File: rtl/pcpi_insn_loader_pkg.sv
// Shared types and constants for the PCPI instruction loader.
//   state_t          : loader FSM encoding (reserved codes decode as COLLECT)
//   NIBBLES_PER_INSN : segments per assembled instruction
//   PCPI_XLEN        : PCPI instruction / result width
package pcpi_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'b00,
    ISSUE   = 2'b01
  } state_t;

  localparam int NIBBLES_PER_INSN = 8;
  localparam int PCPI_XLEN        = 32;

endpackage

// File: rtl/pcpi_insn_loader_pin_sync_edge.sv
// Synchronizes an asynchronous strobe pin together with its data bus and
// emits a single-cycle pulse on each rising strobe edge, with the data
// aligned to that pulse.
//   clk, rst   : clock, async active-high reset
//   i_strobe   : async strobe pin
//   i_data     : async data pins, stable around the strobe edge
//   o_edge     : one-cycle pulse per rising strobe edge
//   o_data     : synchronized data, valid while o_edge is high
module pin_sync_edge #(
  parameter int SYNC_STAGES = 2,
  parameter int WIDTH       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_strobe,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_edge,
  output logic [WIDTH-1:0] o_data
);

  logic [SYNC_STAGES-1:0]            r_str;
  logic [SYNC_STAGES-1:0][WIDTH-1:0] r_dat;
  logic                              r_prev;

  // Data goes through the same number of stages as the strobe so the
  // synchronized nibble is aligned with the detected edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_str  <= '0;
      r_dat  <= '0;
      r_prev <= 1'b0;
    end else begin
      r_str  <= {r_str[SYNC_STAGES-2:0], i_strobe};
      r_dat  <= {r_dat[SYNC_STAGES-2:0], i_data};
      r_prev <= r_str[SYNC_STAGES-1];
    end
  end

  assign o_edge = r_str[SYNC_STAGES-1] & ~r_prev;
  assign o_data = r_dat[SYNC_STAGES-1];

endmodule

// File: rtl/pcpi_insn_loader.sv
// Assembles a 32-bit PCPI instruction from eight nibbles strobed in on slow
// pins (LS nibble first), issues it over a pcpi_valid/pcpi_ready handshake
// with a wait-aware timeout, and captures pcpi_rd for readback.
//   seg_strobe/seg_data : async nibble input pins
//   clear               : sync flush of partial instruction / pending issue
//   seg_ack             : pulse, nibble accepted
//   nib_count           : nibbles held for current instruction
//   busy                : high while issuing
//   pcpi_*              : coprocessor handshake
//   result/result_valid : last captured pcpi_rd and its validity
//   timeout_err         : sticky, last issue timed out
module pcpi_insn_loader
  import pcpi_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 seg_strobe,
  input  logic [3:0]           seg_data,
  input  logic                 clear,
  output logic                 seg_ack,
  output logic [2:0]           nib_count,
  output logic                 busy,
  output logic                 pcpi_valid,
  output logic [PCPI_XLEN-1:0] pcpi_insn,
  input  logic                 pcpi_ready,
  input  logic                 pcpi_wr,
  input  logic                 pcpi_wait,
  input  logic [PCPI_XLEN-1:0] pcpi_rd,
  output logic [PCPI_XLEN-1:0] result,
  output logic                 result_valid,
  output logic                 timeout_err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_t               r_state;
  logic [TW-1:0]        r_tcnt;
  logic [2:0]           r_nib;
  logic [PCPI_XLEN-1:0] r_insn;
  logic [PCPI_XLEN-1:0] r_result;
  logic                 r_valid;
  logic                 r_ack;
  logic                 r_rv;
  logic                 r_terr;
  logic                 w_edge;
  logic [3:0]           w_nib;

  pin_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES),
    .WIDTH      (4)
  ) u_sync (
    .clk     (clk),
    .rst     (rst),
    .i_strobe(seg_strobe),
    .i_data  (seg_data),
    .o_edge  (w_edge),
    .o_data  (w_nib)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= COLLECT;
      r_tcnt   <= '0;
      r_nib    <= '0;
      r_insn   <= '0;
      r_result <= '0;
      r_valid  <= 1'b0;
      r_ack    <= 1'b0;
      r_rv     <= 1'b0;
      r_terr   <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      if (clear) begin
        // Flush only the in-flight work; assembled bits and flags persist.
        r_nib   <= '0;
        r_valid <= 1'b0;
        r_tcnt  <= '0;
        r_state <= COLLECT;
      end else begin
        case (r_state)
          ISSUE: begin
            // Ready is tested first so it wins over a coincident timeout.
            if (pcpi_ready) begin
              r_valid <= 1'b0;
              r_state <= COLLECT;
              r_tcnt  <= '0;
              r_rv    <= 1'b1;
              if (pcpi_wr) r_result <= pcpi_rd;
            end else if (pcpi_wait) begin
              r_tcnt <= '0;
            end else if (r_tcnt == TW'(TIMEOUT - 1)) begin
              r_valid <= 1'b0;
              r_terr  <= 1'b1;
              r_state <= COLLECT;
              r_tcnt  <= '0;
            end else begin
              r_tcnt <= r_tcnt + 1'b1;
            end
          end
          default: begin
            if (w_edge) begin
              r_insn[{r_nib, 2'b00} +: 4] <= w_nib;
              r_ack <= 1'b1;
              // A new instruction invalidates the previous issue's status.
              if (r_nib == 3'd0) begin
                r_terr <= 1'b0;
                r_rv   <= 1'b0;
              end
              if (r_nib == 3'(NIBBLES_PER_INSN - 1)) begin
                r_nib   <= '0;
                r_state <= ISSUE;
                r_valid <= 1'b1;
              end else begin
                r_nib <= r_nib + 1'b1;
              end
            end
          end
        endcase
      end
    end
  end

  assign seg_ack      = r_ack;
  assign nib_count    = r_nib;
  assign busy         = (r_state == ISSUE);
  assign pcpi_valid   = r_valid;
  assign pcpi_insn    = r_insn;
  assign result       = r_result;
  assign result_valid = r_rv;
  assign timeout_err  = r_terr;

endmodule

// File: tb/tb_pcpi_insn_loader.sv
module tb_pcpi_insn_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        seg_strobe = 1'b0;
  logic [3:0]  seg_data = '0;
  logic        clear = 1'b0;
  logic        seg_ack;
  logic [2:0]  nib_count;
  logic        busy;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn;
  logic        pcpi_ready = 1'b0;
  logic        pcpi_wr = 1'b0;
  logic        pcpi_wait = 1'b0;
  logic [31:0] pcpi_rd = '0;
  logic [31:0] result;
  logic        result_valid;
  logic        timeout_err;

  int n_assert = 0;
  int n_fail   = 0;
  int acks     = 0;
  int lat      = 0;

  always #5 clk = ~clk;

  pcpi_insn_loader #(.SYNC_STAGES(2), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .seg_strobe(seg_strobe), .seg_data(seg_data),
    .clear(clear), .seg_ack(seg_ack), .nib_count(nib_count), .busy(busy),
    .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn), .pcpi_ready(pcpi_ready),
    .pcpi_wr(pcpi_wr), .pcpi_wait(pcpi_wait), .pcpi_rd(pcpi_rd),
    .result(result), .result_valid(result_valid), .timeout_err(timeout_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ack"},   32'(seg_ack),      0);
    chk({tag, "_nib"},   32'(nib_count),    0);
    chk({tag, "_busy"},  32'(busy),         0);
    chk({tag, "_valid"}, 32'(pcpi_valid),   0);
    chk({tag, "_insn"},  pcpi_insn,         0);
    chk({tag, "_res"},   result,            0);
    chk({tag, "_rv"},    32'(result_valid), 0);
    chk({tag, "_terr"},  32'(timeout_err),  0);
  endtask

  // Raise the strobe, wait (bounded) for seg_ack, drop it, idle `gap` cycles.
  task automatic send_nib(input logic [3:0] n, input int gap);
    bit got = 0;
    seg_data   = n;
    seg_strobe = 1'b1;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      if (seg_ack) begin got = 1; lat = k + 1; end
    end
    chk("ack_seen", 32'(got), 1);
    acks += int'(got);
    seg_strobe = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  // Sends all eight nibbles; returns on the cycle of the last seg_ack.
  task automatic send_insn(input logic [31:0] w);
    for (int i = 0; i < 8; i++) send_nib(w[4*i +: 4], (i == 7) ? 0 : 2);
  endtask

  initial begin
    int cnt;
    // Reset state
    @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Basic assembly 8,7,...,1 -> 0x12345678
    acks = 0;
    send_nib(4'h8, 2);
    chk("latency", 32'(lat), 3);
    for (int i = 1; i < 8; i++) send_nib(4'(8 - i), (i == 7) ? 0 : 2);
    chk("acks8", 32'(acks), 8);
    chk("insn1", pcpi_insn, 32'h12345678);
    chk("valid1", 32'(pcpi_valid), 1);
    chk("busy1", 32'(busy), 1);
    chk("nib_after_full", 32'(nib_count), 0);

    // Ready+wr on the 5th valid cycle
    repeat (4) @(negedge clk);
    chk("valid_c5", 32'(pcpi_valid), 1);
    pcpi_ready = 1'b1; pcpi_wr = 1'b1; pcpi_rd = 32'hDEADBEEF;
    @(negedge clk);
    pcpi_ready = 1'b0; pcpi_wr = 1'b0;
    chk("valid_drop", 32'(pcpi_valid), 0);
    chk("busy_drop", 32'(busy), 0);
    chk("result1", result, 32'hDEADBEEF);
    chk("rv1", 32'(result_valid), 1);
    chk("terr1", 32'(timeout_err), 0);
    repeat (2) @(negedge clk);

    // Timeout: valid must stay high exactly 16 cycles
    send_insn(32'h87654321);
    cnt = 0;
    while (pcpi_valid && cnt < 40) begin cnt++; @(negedge clk); end
    chk("timeout_len", 32'(cnt), 16);
    chk("terr_set", 32'(timeout_err), 1);
    chk("rv_cleared", 32'(result_valid), 0);
    chk("result_kept", result, 32'hDEADBEEF);
    chk("busy_to", 32'(busy), 0);
    repeat (2) @(negedge clk);

    // First nibble of next instruction clears the error; wait holds issue
    pcpi_wait = 1'b1;
    send_nib(4'h5, 2);
    chk("terr_clr", 32'(timeout_err), 0);
    for (int i = 1; i < 8; i++) send_nib(4'((i & 1) ? 4'hA : 4'h5), (i == 7) ? 0 : 2);
    chk("insn_wait", pcpi_insn, 32'hA5A5A5A5);
    repeat (100) @(negedge clk);
    chk("valid_wait", 32'(pcpi_valid), 1);
    chk("terr_wait", 32'(timeout_err), 0);
    pcpi_wait = 1'b0; pcpi_ready = 1'b1; pcpi_wr = 1'b1; pcpi_rd = 32'h000000A5;
    @(negedge clk);
    pcpi_ready = 1'b0; pcpi_wr = 1'b0;
    chk("valid_wait_done", 32'(pcpi_valid), 0);
    chk("result_a5", result, 32'h000000A5);
    chk("terr_wait_done", 32'(timeout_err), 0);
    repeat (2) @(negedge clk);

    // Ready (no wr) coincident with the 16th valid cycle
    send_insn(32'h0F0F0F0F);
    repeat (15) @(negedge clk);
    chk("valid_c16", 32'(pcpi_valid), 1);
    pcpi_ready = 1'b1;
    @(negedge clk);
    pcpi_ready = 1'b0;
    chk("race_valid", 32'(pcpi_valid), 0);
    chk("race_terr", 32'(timeout_err), 0);
    chk("race_rv", 32'(result_valid), 1);
    chk("race_res", result, 32'h000000A5);
    repeat (2) @(negedge clk);

    // Strobe held high 10 cycles -> one nibble
    acks = 0;
    seg_data = 4'h9; seg_strobe = 1'b1;
    repeat (10) begin @(negedge clk); acks += int'(seg_ack); end
    seg_strobe = 1'b0;
    repeat (3) @(negedge clk);
    chk("held_acks", 32'(acks), 1);
    chk("held_nib", 32'(nib_count), 1);
    for (int i = 1; i < 8; i++) send_nib(4'(i), (i == 7) ? 0 : 2);
    chk("insn_held", pcpi_insn, 32'h76543219);

    // Strobes during ISSUE are ignored
    pcpi_wait = 1'b1;
    acks = 0;
    seg_data = 4'hF;
    repeat (3) begin
      seg_strobe = 1'b1;
      repeat (3) begin @(negedge clk); acks += int'(seg_ack); end
      seg_strobe = 1'b0;
      repeat (3) begin @(negedge clk); acks += int'(seg_ack); end
    end
    chk("issue_acks", 32'(acks), 0);
    chk("issue_insn", pcpi_insn, 32'h76543219);
    chk("issue_valid", 32'(pcpi_valid), 1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0; pcpi_wait = 1'b0;
    chk("clr_issue_valid", 32'(pcpi_valid), 0);
    chk("clr_issue_busy", 32'(busy), 0);
    repeat (2) @(negedge clk);

    // Clear after 3 nibbles keeps low bits, next 8 form a full instruction
    send_nib(4'hA, 2); send_nib(4'hB, 2); send_nib(4'hC, 2);
    chk("nib3", 32'(nib_count), 3);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clr_nib", 32'(nib_count), 0);
    chk("clr_insn", pcpi_insn, 32'h76543CBA);
    repeat (2) @(negedge clk);
    send_insn(32'hCAFEF00D);
    chk("insn_after_clr", pcpi_insn, 32'hCAFEF00D);
    chk("valid_after_clr", 32'(pcpi_valid), 1);
    pcpi_ready = 1'b1; pcpi_wr = 1'b1; pcpi_rd = 32'h13579BDF;
    @(negedge clk);
    pcpi_ready = 1'b0; pcpi_wr = 1'b0;
    chk("result_last", result, 32'h13579BDF);
    repeat (2) @(negedge clk);

    // Async reset mid-collection
    send_nib(4'h1, 2); send_nib(4'h2, 2); send_nib(4'h3, 0);
    chk("nib_pre_rst", 32'(nib_count), 3);
    #2 rst = 1'b1;
    #1 chk_zero("async_rst");
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
